owl_burst_ctrl: RTL and testbench

- Frame-level one-wire slave controller: sits between the byte-level one-wire transceiver and the SFR register bus.
- Receives a command frame with a full address byte and a burst length, checks it with CRC-16, and commits or fetches multiple SFR bytes.
- Returns a status/data response frame.
- Generation-two controller: adds parametrised address width, buffered multi-byte write bursts committed only on good CRC, auto-increment read bursts, an inter-byte timeout, and an optional error-response mode.

---
 rtl/owl_pkg.sv | 51 +++++
 rtl/crc16_byte.sv | 34 +++
 rtl/owl_burst_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_owl_burst_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/owl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : owl_pkg
// Description : Shared types and constants for the one-wire burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
package owl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RX_CMD  = 4'd1,
        S_RX_ADDR = 4'd2,
        S_RX_LEN  = 4'd3,
        S_RX_DATA = 4'd4,
        S_RX_CRC0 = 4'd5,
        S_RX_CRC1 = 4'd6,
        S_RX_EOF  = 4'd7,
        S_TURN    = 4'd8,
        S_COMMIT  = 4'd9,
        S_TX_STAT = 4'd10,
        S_TX_RD   = 4'd11,
        S_TX_DATA = 4'd12,
        S_TX_CRC0 = 4'd13,
        S_TX_CRC1 = 4'd14,
        S_DONE    = 4'd15
    } state_t;

    localparam int ST_VALID   = 7;
    localparam int ST_OVF     = 6;
    localparam int ST_LEN     = 5;
    localparam int ST_CRC     = 2;
    localparam int ST_CMD     = 1;
    localparam int ST_BIT     = 0;

    localparam int CMD_WR_BIT = 7;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    // Reflected CRC-16 update, LSB of the byte first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_byte.sv
`default_nettype none
// ============================================================================
// Module      : crc16_byte
// Description : Byte-wide CRC-16/MODBUS accumulator with clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_byte
    import owl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    always_comb w_crc_next = crc16_next(r_crc, din);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/owl_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : owl_burst_ctrl
// Description : Frame-level one-wire slave: CRC-checked burst SFR access.
// Revision    : 1.0 - initial release
// ============================================================================
module owl_burst_ctrl
    import owl_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_BURST = 8,
    parameter int TO_CYCLES = 4095,
    parameter int TA_CYCLES = 64,
    parameter int ERR_RESP  = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_sof,
    input  logic              rx_vld,
    input  logic [7:0]        rx_data,
    input  logic              rx_eof,
    input  logic              rx_bit_err,
    output logic              tx_vld,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    input  logic              tx_idle,
    output logic [ADDR_W-1:0] sfr_addr,
    output logic [7:0]        sfr_wdata,
    output logic              sfr_wr,
    output logic              sfr_rd,
    input  logic [7:0]        sfr_rdata,
    input  logic              sfr_ready,
    output logic              busy,
    output logic [7:0]        last_status
);

    localparam int c_cnt_max = (TO_CYCLES > TA_CYCLES) ? TO_CYCLES : TA_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_idx_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TO_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ta_last = c_cnt_w'(TA_CYCLES - 1);
    localparam logic [7:0]         c_max_len = 8'(MAX_BURST - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_idx;
    logic [7:0]         r_buf [MAX_BURST];
    logic               r_ovf_err, r_len_err, r_crc_err, r_cmd_err, r_bit_err;
    logic [7:0]         r_rd_byte;
    logic               r_tx_vld;
    logic [7:0]         r_tx_data;
    logic [ADDR_W-1:0]  r_sfr_addr;
    logic [7:0]         r_sfr_wdata;
    logic               r_sfr_wr, r_sfr_rd;
    logic [7:0]         r_last_status;

    logic [15:0]        w_rx_crc, w_tx_crc;
    logic               w_rx_crc_en, w_tx_crc_en, w_tx_hs, w_buf_we;
    logic [7:0]         w_status;
    logic               w_err, w_last, w_good_read;
    logic [ADDR_W-1:0]  w_cur_addr;

    assign w_rx_crc_en = rx_vld && (r_state inside {S_RX_CMD, S_RX_ADDR, S_RX_LEN,
                                                    S_RX_DATA, S_RX_CRC0, S_RX_CRC1});
    assign w_tx_hs     = r_tx_vld && tx_rdy;
    assign w_tx_crc_en = w_tx_hs && (r_state inside {S_TX_STAT, S_TX_DATA});
    assign w_buf_we    = (r_state == S_RX_DATA) && rx_vld && !rx_eof && !r_len_err;
    assign w_status    = {1'b1, r_ovf_err, r_len_err, 2'b00, r_crc_err, r_cmd_err, r_bit_err};
    assign w_err       = |w_status[ST_OVF:ST_BIT];
    assign w_last      = (r_idx == r_len);
    assign w_cur_addr  = r_addr + r_idx[ADDR_W-1:0];
    assign w_good_read = !r_is_wr && (r_last_status[ST_OVF:ST_BIT] == 7'd0);

    crc16_byte u_rx_crc (
        .clk (clk), .rst (rst), .clr (r_state == S_IDLE),
        .en  (w_rx_crc_en), .din (rx_data), .crc (w_rx_crc)
    );

    crc16_byte u_tx_crc (
        .clk (clk), .rst (rst), .clr (r_state == S_TURN),
        .en  (w_tx_crc_en), .din (r_tx_data), .crc (w_tx_crc)
    );

    // Write buffer has no reset: it is only read after a complete, checked frame.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx[c_idx_w-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_is_wr       <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_ovf_err     <= 1'b0;
            r_len_err     <= 1'b0;
            r_crc_err     <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_bit_err     <= 1'b0;
            r_rd_byte     <= '0;
            r_tx_vld      <= 1'b0;
            r_tx_data     <= '0;
            r_sfr_addr    <= '0;
            r_sfr_wdata   <= '0;
            r_sfr_wr      <= 1'b0;
            r_sfr_rd      <= 1'b0;
            r_last_status <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (rx_bit_err && (r_state != S_IDLE)) begin
                r_bit_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (rx_sof) begin
                        r_state   <= S_RX_CMD;
                        r_cnt     <= '0;
                        r_ovf_err <= 1'b0;
                        r_len_err <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_cmd_err <= 1'b0;
                        r_bit_err <= 1'b0;
                    end
                end
                S_RX_CMD, S_RX_ADDR, S_RX_LEN, S_RX_DATA, S_RX_CRC0, S_RX_CRC1, S_RX_EOF: begin
                    if (rx_vld || rx_eof) begin
                        r_cnt <= '0;
                    end
                    if (rx_eof && (r_state != S_RX_EOF)) begin
                        // A frame that ends early is treated as a length error.
                        r_len_err <= 1'b1;
                        r_state   <= S_TURN;
                    end else if (rx_eof) begin
                        r_crc_err <= (w_rx_crc != 16'h0000);
                        r_state   <= S_TURN;
                    end else if (rx_vld) begin
                        case (r_state)
                            S_RX_CMD: begin
                                r_is_wr   <= rx_data[CMD_WR_BIT];
                                r_cmd_err <= |rx_data[CMD_WR_BIT-1:0];
                                r_state   <= S_RX_ADDR;
                            end
                            S_RX_ADDR: begin
                                r_addr  <= rx_data[ADDR_W-1:0];
                                r_state <= S_RX_LEN;
                            end
                            S_RX_LEN: begin
                                r_len <= rx_data;
                                r_idx <= '0;
                                if (rx_data > c_max_len) begin
                                    r_len_err <= 1'b1;
                                end
                                r_state <= r_is_wr ? S_RX_DATA : S_RX_CRC0;
                            end
                            S_RX_DATA: begin
                                if (w_last) begin
                                    r_state <= S_RX_CRC0;
                                end else begin
                                    r_idx <= r_idx + 8'd1;
                                end
                            end
                            S_RX_CRC0: r_state <= S_RX_CRC1;
                            S_RX_CRC1: r_state <= S_RX_EOF;
                            default:   r_len_err <= 1'b1;
                        endcase
                    end else if (r_cnt == c_to_last) begin
                        r_ovf_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_TURN;
                    end
                end
                S_TURN: begin
                    r_last_status <= w_status;
                    if (r_cnt == c_ta_last) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (w_err) begin
                            r_state <= (ERR_RESP != 0) ? S_TX_STAT : S_IDLE;
                        end else begin
                            r_state <= r_is_wr ? S_COMMIT : S_TX_STAT;
                        end
                    end
                end
                S_COMMIT: begin
                    if (!r_sfr_wr) begin
                        r_sfr_wr    <= 1'b1;
                        r_sfr_addr  <= w_cur_addr;
                        r_sfr_wdata <= r_buf[r_idx[c_idx_w-1:0]];
                    end else if (sfr_ready) begin
                        r_sfr_wr <= 1'b0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_TX_STAT;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_TX_STAT: begin
                    if (!r_tx_vld) begin
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= r_last_status;
                    end else if (tx_rdy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= w_good_read ? S_TX_RD : S_TX_CRC0;
                    end
                end
                S_TX_RD: begin
                    if (!r_sfr_rd) begin
                        r_sfr_rd   <= 1'b1;
                        r_sfr_addr <= w_cur_addr;
                    end else if (sfr_ready) begin
                        r_sfr_rd  <= 1'b0;
                        r_rd_byte <= sfr_rdata;
                        r_state   <= S_TX_DATA;
                    end
                end
                S_TX_DATA: begin
                    if (!r_tx_vld) begin
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= r_rd_byte;
                    end else if (tx_rdy) begin
                        r_tx_vld <= 1'b0;
                        if (w_last) begin
                            r_state <= S_TX_CRC0;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_TX_RD;
                        end
                    end
                end
                S_TX_CRC0: begin
                    if (!r_tx_vld) begin
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= w_tx_crc[7:0];
                    end else if (tx_rdy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= S_TX_CRC1;
                    end
                end
                S_TX_CRC1: begin
                    if (!r_tx_vld) begin
                        r_tx_vld  <= 1'b1;
                        r_tx_data <= w_tx_crc[15:8];
                    end else if (tx_rdy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (tx_idle) begin
                        r_state   <= S_IDLE;
                        r_ovf_err <= 1'b0;
                        r_len_err <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_cmd_err <= 1'b0;
                        r_bit_err <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_vld      = r_tx_vld;
    assign tx_data     = r_tx_data;
    assign sfr_addr    = r_sfr_addr;
    assign sfr_wdata   = r_sfr_wdata;
    assign sfr_wr      = r_sfr_wr;
    assign sfr_rd      = r_sfr_rd;
    assign busy        = (r_state != S_IDLE);
    assign last_status = r_last_status;

endmodule
`default_nettype wire

// File: tb/tb_owl_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_owl_burst_ctrl
// Description : Directed, scoreboarded bench for owl_burst_ctrl and crc16_byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_owl_burst_ctrl;

    logic       clk, rst;
    logic       rx_sof1, rx_sof2, rx_vld, rx_eof, rx_bit_err;
    logic [7:0] rx_data;
    logic       tx_rdy, tx_idle;
    logic [7:0] sfr_rdata;
    logic       sfr_ready;
    logic       sfr_ready2;
    logic [7:0] sfr_rdata2;

    logic       tx_vld1, sfr_wr1, sfr_rd1, busy1;
    logic [7:0] tx_data1, sfr_wdata1, last_status1;
    logic [5:0] sfr_addr1;
    logic       tx_vld2, sfr_wr2, sfr_rd2, busy2;
    logic [7:0] tx_data2, sfr_wdata2, last_status2;
    logic [5:0] sfr_addr2;

    logic        crc_clr, crc_en;
    logic [7:0]  crc_din;
    logic [15:0] crc_out;

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    int wr_hs  = 0;

    logic [7:0]  mem [64];
    logic [7:0]  exp_tx1[$];
    logic [7:0]  exp_tx2[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    owl_burst_ctrl u_dut (
        .clk(clk), .rst(rst), .rx_sof(rx_sof1), .rx_vld(rx_vld), .rx_data(rx_data),
        .rx_eof(rx_eof), .rx_bit_err(rx_bit_err), .tx_vld(tx_vld1), .tx_data(tx_data1),
        .tx_rdy(tx_rdy), .tx_idle(tx_idle), .sfr_addr(sfr_addr1), .sfr_wdata(sfr_wdata1),
        .sfr_wr(sfr_wr1), .sfr_rd(sfr_rd1), .sfr_rdata(sfr_rdata), .sfr_ready(sfr_ready),
        .busy(busy1), .last_status(last_status1)
    );

    owl_burst_ctrl #(.ERR_RESP(1)) u_dut_er (
        .clk(clk), .rst(rst), .rx_sof(rx_sof2), .rx_vld(rx_vld), .rx_data(rx_data),
        .rx_eof(rx_eof), .rx_bit_err(rx_bit_err), .tx_vld(tx_vld2), .tx_data(tx_data2),
        .tx_rdy(tx_rdy), .tx_idle(tx_idle), .sfr_addr(sfr_addr2), .sfr_wdata(sfr_wdata2),
        .sfr_wr(sfr_wr2), .sfr_rd(sfr_rd2), .sfr_rdata(sfr_rdata2), .sfr_ready(sfr_ready2),
        .busy(busy2), .last_status(last_status2)
    );

    crc16_byte u_crc (
        .clk(clk), .rst(rst), .clr(crc_clr), .en(crc_en), .din(crc_din), .crc(crc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) begin
            c ^= {8'h00, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input logic cond);
        check(tag, {15'd0, cond}, 16'h0001);
    endtask

    // Responders: toggling tx_rdy, SFR slave with a short ready latency.
    always @(posedge clk) begin
        if (rst) begin
            tx_rdy    <= 1'b0;
            sfr_ready <= 1'b0;
            lat       <= 0;
        end else begin
            tx_rdy <= ~tx_rdy;
            if (sfr_ready) begin
                sfr_ready <= 1'b0;
                lat       <= 0;
            end else if (sfr_wr1 || sfr_rd1) begin
                if (lat == 2) begin
                    sfr_ready <= 1'b1;
                    sfr_rdata <= mem[sfr_addr1];
                    lat       <= 0;
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    // Scoreboard: every handshake pops the next expected item.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_vld1 && tx_rdy) begin
                check_true("tx1_expected", exp_tx1.size() != 0);
                if (exp_tx1.size() != 0) check("tx1_byte", {8'h00, tx_data1}, {8'h00, exp_tx1.pop_front()});
            end
            if (tx_vld2 && tx_rdy) begin
                check_true("tx2_expected", exp_tx2.size() != 0);
                if (exp_tx2.size() != 0) check("tx2_byte", {8'h00, tx_data2}, {8'h00, exp_tx2.pop_front()});
            end
            if (sfr_wr1 && sfr_ready) begin
                wr_hs++;
                check_true("wr_excl_rd", !sfr_rd1);
                check_true("wr_expected", exp_wr.size() != 0);
                if (exp_wr.size() != 0) check("wr_addr_data", {2'b00, sfr_addr1, sfr_wdata1}, exp_wr.pop_front());
            end
            if (sfr_rd1 && sfr_ready) begin
                check_true("rd_expected", exp_rd.size() != 0);
                if (exp_rd.size() != 0) check("rd_addr", {10'd0, sfr_addr1}, {8'h00, exp_rd.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] body[$], input bit to2, input logic [15:0] crc_xor);
        logic [15:0] c;
        c = crc_model(body) ^ crc_xor;
        @(negedge clk);
        if (to2) rx_sof2 = 1'b1; else rx_sof1 = 1'b1;
        @(negedge clk);
        rx_sof1 = 1'b0;
        rx_sof2 = 1'b0;
        foreach (body[i]) send_byte(body[i]);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
        rx_eof = 1'b1;
        @(negedge clk);
        rx_eof = 1'b0;
    endtask

    task automatic push_resp(input logic [7:0] q[$], input bit to2);
        logic [15:0] c;
        c = crc_model(q);
        foreach (q[i]) begin
            if (to2) exp_tx2.push_back(q[i]); else exp_tx1.push_back(q[i]);
        end
        if (to2) begin
            exp_tx2.push_back(c[7:0]);
            exp_tx2.push_back(c[15:8]);
        end else begin
            exp_tx1.push_back(c[7:0]);
            exp_tx1.push_back(c[15:8]);
        end
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n = 0;
        while ((sel ? busy2 : busy1) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_true({tag, "_idle"}, !(sel ? busy2 : busy1));
    endtask

    initial begin
        logic [7:0] body[$];
        logic [7:0] resp[$];
        string      s;
        int         n;

        rst = 1'b1; rx_sof1 = 1'b0; rx_sof2 = 1'b0; rx_vld = 1'b0; rx_eof = 1'b0;
        rx_bit_err = 1'b0; rx_data = 8'h00; tx_idle = 1'b1; sfr_rdata = 8'h00;
        sfr_ready2 = 1'b0; sfr_rdata2 = 8'h00;
        crc_clr = 1'b0; crc_en = 1'b0; crc_din = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[5] = 8'hA5;
        mem[6] = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_tx",   {7'd0, tx_vld1, tx_data1}, 16'h0000);
        check("rst_sfr",  {sfr_wr1, sfr_rd1, sfr_addr1, sfr_wdata1}, 16'h0000);
        check("rst_stat", {7'd0, busy1, last_status1}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // CRC unit: check value and zero residue
        s = "123456789";
        crc_clr = 1'b1;
        @(negedge clk);
        crc_clr = 1'b0;
        crc_en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            crc_din = s[i];
            @(negedge clk);
        end
        crc_en = 1'b0;
        check("crc_check", crc_out, 16'h4B37);
        crc_en  = 1'b1;
        crc_din = 8'h37;
        @(negedge clk);
        crc_din = 8'h4B;
        @(negedge clk);
        crc_en = 1'b0;
        check("crc_residue", crc_out, 16'h0000);

        // Write burst wrapping past the top of the 6-bit address space
        body = '{8'h80, 8'h3E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_wr.push_back(16'h3E11);
        exp_wr.push_back(16'h3F22);
        exp_wr.push_back(16'h0033);
        exp_wr.push_back(16'h0144);
        resp = '{8'h80};
        push_resp(resp, 1'b0);
        send_frame(body, 1'b0, 16'h0000);
        wait_idle(1'b0, "wr_burst");
        check("wr_burst_status", {8'h00, last_status1}, 16'h0080);
        check_true("wr_burst_drained", (exp_wr.size() == 0) && (exp_tx1.size() == 0));

        // Read burst with auto-increment
        body = '{8'h00, 8'h05, 8'h01};
        exp_rd.push_back(8'h05);
        exp_rd.push_back(8'h06);
        resp = '{8'h80, 8'hA5, 8'h5A};
        push_resp(resp, 1'b0);
        send_frame(body, 1'b0, 16'h0000);
        wait_idle(1'b0, "rd_burst");
        check("rd_burst_status", {8'h00, last_status1}, 16'h0080);
        check_true("rd_burst_drained", (exp_rd.size() == 0) && (exp_tx1.size() == 0));

        // Corrupted CRC_H, silent drop
        body = '{8'h80, 8'h10, 8'h00, 8'h77};
        send_frame(body, 1'b0, 16'h0100);
        wait_idle(1'b0, "crc_drop");
        check("crc_drop_status", {8'h00, last_status1}, 16'h0084);

        // Corrupted CRC_H, error response variant
        resp = '{8'h84};
        push_resp(resp, 1'b1);
        send_frame(body, 1'b1, 16'h0100);
        wait_idle(1'b1, "crc_resp");
        check("crc_resp_status", {8'h00, last_status2}, 16'h0084);
        check_true("crc_resp_drained", exp_tx2.size() == 0);

        // Read longer than the buffer depth
        body = '{8'h00, 8'h05, 8'h08};
        send_frame(body, 1'b0, 16'h0000);
        wait_idle(1'b0, "len_err");
        check("len_err_status", {8'h00, last_status1}, 16'h00A0);

        // Reserved command bits set
        body = '{8'h01, 8'h05, 8'h00};
        send_frame(body, 1'b0, 16'h0000);
        wait_idle(1'b0, "cmd_err");
        check("cmd_err_status", {8'h00, last_status1}, 16'h0082);

        // Stall after the address byte
        @(negedge clk);
        rx_sof1 = 1'b1;
        @(negedge clk);
        rx_sof1 = 1'b0;
        send_byte(8'h80);
        send_byte(8'h3E);
        wait_idle(1'b0, "timeout");
        check("timeout_status", {8'h00, last_status1}, 16'h00C0);

        // Reset while a 4-byte commit is in flight
        body = '{8'h80, 8'h20, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_wr.push_back(16'h2001);
        exp_wr.push_back(16'h2102);
        resp = '{8'h80};
        send_frame(body, 1'b0, 16'h0000);
        n = wr_hs + 2;
        for (int i = 0; i < 2000 && wr_hs < n; i++) @(negedge clk);
        check_true("commit_two_writes", wr_hs >= n);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx",   {7'd0, tx_vld1, tx_data1}, 16'h0000);
        check("rst_mid_sfr",  {sfr_wr1, sfr_rd1, sfr_addr1, sfr_wdata1}, 16'h0000);
        check("rst_mid_stat", {7'd0, busy1, last_status1}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check_true("rst_mid_no_more", (exp_wr.size() == 0) && !busy1);
        check_true("final_drained", (exp_tx1.size() == 0) && (exp_tx2.size() == 0) && (exp_rd.size() == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
